// File: rtl/mem_sync_hs.sv
// Single-port synchronous memory with req/ready request side and o_valid/o_ready response side.
// Define MEM_PARITY_EN to store an even-parity bit per word and flag mismatches on perr.
module mem_sync_hs #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              RW,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] i,
  output logic              ready,
  output logic [DATA_W-1:0] o,
  output logic              o_valid,
  input  logic              o_ready,
  output logic              perr
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {IDLE, RESP} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] o_q, o_d;
  logic              perr_q, perr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_word;
  logic              rd_perr;
  logic              accept, wr_en, rd_en;

  assign o_valid = (state_q == RESP);
  assign ready   = !o_valid || o_ready;
  assign accept  = req && ready;
  assign wr_en   = accept && !RW;
  assign rd_en   = accept && RW;
  assign rd_word = mem_q[addr];
  assign o       = o_q;
  assign perr    = perr_q;

  // Each word is its own register so reset can clear the whole array at once.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem_q[gi] <= '0;
      end else if (wr_en && (addr == ADDR_W'(gi))) begin
        mem_q[gi] <= i;
      end
    end
  end

`ifdef MEM_PARITY_EN
  logic par_q [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_par
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        par_q[gi] <= 1'b0;
      end else if (wr_en && (addr == ADDR_W'(gi))) begin
        par_q[gi] <= ^i;
      end
    end
  end

  assign rd_perr = (^rd_word) != par_q[addr];
`else
  assign rd_perr = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      o_q     <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      o_q     <= o_d;
      perr_q  <= perr_d;
    end
  end

  // o holds its last value after a handshake; perr drops together with o_valid.
  always_comb begin
    state_d = state_q;
    o_d     = o_q;
    perr_d  = perr_q;
    case (state_q)
      IDLE: begin
        if (rd_en) begin
          state_d = RESP;
          o_d     = rd_word;
          perr_d  = rd_perr;
        end
      end
      RESP: begin
        if (o_ready) begin
          if (rd_en) begin
            o_d    = rd_word;
            perr_d = rd_perr;
          end else begin
            state_d = IDLE;
            perr_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        perr_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_sync_hs.sv
// Directed bench for mem_sync_hs: reset, write/read, hold, back-to-back and mid-response reset.
module tb_mem_sync_hs;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0;
  logic       RW = 1'b0;
  logic [2:0] addr = '0;
  logic [7:0] i = '0;
  logic       ready;
  logic [7:0] o;
  logic       o_valid;
  logic       o_ready = 1'b1;
  logic       perr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_sync_hs #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .RW(RW), .addr(addr), .i(i),
    .ready(ready), .o(o), .o_valid(o_valid), .o_ready(o_ready), .perr(perr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [7:0] d);
    req = 1'b1; RW = 1'b0; addr = a; i = d;
    step();
    req = 1'b0;
    $display("txn write addr=%0d data=%0d", a, d);
  endtask

  task automatic do_read(input logic [2:0] a, input logic [7:0] d);
    req = 1'b1; RW = 1'b1; addr = a; i = d;
    step();
    req = 1'b0;
    $display("txn read addr=%0d o=%0d o_valid=%0b perr=%0b", a, o, o_valid, perr);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp++; if (o !== 8'd0)     begin n_err++; $display("FAIL reset_o got=%0d exp=0", o); end
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%0b exp=0", o_valid); end
    n_cmp++; if (ready !== 1'b1)  begin n_err++; $display("FAIL reset_ready got=%0b exp=1", ready); end
    n_cmp++; if (perr !== 1'b0)   begin n_err++; $display("FAIL reset_perr got=%0b exp=0", perr); end
    step();
    rst_n = 1'b1;
    step();
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_valid got=%0b exp=0", o_valid); end
    $display("txn reset done");
  endtask

  task automatic test_write_read();
    o_ready = 1'b1;
    do_write(3'd7, 8'd4);
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL write_no_resp got=%0b exp=0", o_valid); end
    do_write(3'd3, 8'd2);
    do_read(3'd3, 8'd0);
    n_cmp++; if (o !== 8'd2)       begin n_err++; $display("FAIL rd3_o got=%0d exp=2", o); end
    n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL rd3_valid got=%0b exp=1", o_valid); end
    n_cmp++; if (perr !== 1'b0)    begin n_err++; $display("FAIL rd3_perr got=%0b exp=0", perr); end
    do_read(3'd7, 8'd0);
    n_cmp++; if (o !== 8'd4)       begin n_err++; $display("FAIL rd7_o got=%0d exp=4", o); end
    n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL rd7_valid got=%0b exp=1", o_valid); end
    step();
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL drain_valid got=%0b exp=0", o_valid); end
    n_cmp++; if (o !== 8'd4)       begin n_err++; $display("FAIL drain_o_hold got=%0d exp=4", o); end
    // write immediately followed by read of the same word must see the new data
    do_write(3'd5, 8'hA5);
    do_read(3'd5, 8'd0);
    n_cmp++; if (o !== 8'hA5)      begin n_err++; $display("FAIL wr_rd_same got=%0h exp=a5", o); end
    step();
  endtask

  task automatic test_read_ignores_i();
    o_ready = 1'b1;
    do_read(3'd1, 8'd5);
    n_cmp++; if (o !== 8'd0)       begin n_err++; $display("FAIL rd1_o got=%0d exp=0", o); end
    n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL rd1_valid got=%0b exp=1", o_valid); end
    step();
    do_read(3'd1, 8'd0);
    n_cmp++; if (o !== 8'd0)       begin n_err++; $display("FAIL rd1_again got=%0d exp=0", o); end
    step();
  endtask

  task automatic test_hold();
    o_ready = 1'b0;
    do_read(3'd3, 8'd0);
    n_cmp++; if (o !== 8'd2)       begin n_err++; $display("FAIL hold_first_o got=%0d exp=2", o); end
    for (int k = 0; k < 3; k++) begin
      req = 1'b1; RW = 1'b1; addr = 3'd7;
      #1;
      n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL hold_ready[%0d] got=%0b exp=0", k, ready); end
      step();
      n_cmp++; if (o !== 8'd2)     begin n_err++; $display("FAIL hold_o[%0d] got=%0d exp=2", k, o); end
      n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL hold_valid[%0d] got=%0b exp=1", k, o_valid); end
      $display("txn stalled req cycle=%0d o=%0d", k, o);
    end
    req = 1'b0;
    o_ready = 1'b1;
    #1;
    n_cmp++; if (ready !== 1'b1)   begin n_err++; $display("FAIL hold_release_ready got=%0b exp=1", ready); end
    step();
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL hold_release_valid got=%0b exp=0", o_valid); end
    n_cmp++; if (o !== 8'd2)       begin n_err++; $display("FAIL hold_release_o got=%0d exp=2", o); end
  endtask

  task automatic test_back_to_back();
    o_ready = 1'b1;
    req = 1'b1; RW = 1'b1; addr = 3'd7;
    step();
    n_cmp++; if (o !== 8'd4)       begin n_err++; $display("FAIL b2b_first got=%0d exp=4", o); end
    n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL b2b_first_valid got=%0b exp=1", o_valid); end
    $display("txn b2b read addr=7 o=%0d", o);
    addr = 3'd3;
    step();
    n_cmp++; if (o !== 8'd2)       begin n_err++; $display("FAIL b2b_second got=%0d exp=2", o); end
    n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL b2b_second_valid got=%0b exp=1", o_valid); end
    $display("txn b2b read addr=3 o=%0d", o);
    req = 1'b0;
    step();
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain got=%0b exp=0", o_valid); end
  endtask

  task automatic test_reset_mid();
    o_ready = 1'b0;
    do_read(3'd7, 8'd0);
    n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre_valid got=%0b exp=1", o_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL mid_async_valid got=%0b exp=0", o_valid); end
    n_cmp++; if (o !== 8'd0)       begin n_err++; $display("FAIL mid_async_o got=%0d exp=0", o); end
    step();
    rst_n = 1'b1;
    o_ready = 1'b1;
    step();
    $display("txn reset pulse mid-response");
    do_read(3'd7, 8'd0);
    n_cmp++; if (o !== 8'd0)       begin n_err++; $display("FAIL mid_rd7_o got=%0d exp=0", o); end
    n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL mid_rd7_valid got=%0b exp=1", o_valid); end
    n_cmp++; if (perr !== 1'b0)    begin n_err++; $display("FAIL mid_rd7_perr got=%0b exp=0", perr); end
    do_read(3'd3, 8'd0);
    n_cmp++; if (o !== 8'd0)       begin n_err++; $display("FAIL mid_rd3_o got=%0d exp=0", o); end
    step();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_read_ignores_i();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
